// File: rtl/rf_wb_serializer_pkg.sv
// Shared helpers for the writeback serializer and its register-file neighbours.
//   log2(v) : ceiling log2, minimum 1, used for address/pointer/count widths.
package rf_wb_serializer_pkg;

  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rf_wb_serializer_compact.sv
// wb_compact: combinational lane compaction.
// Packs the valid lanes of a write bundle into slots 0..nv-1 in ascending
// lane order and reports nv = popcount(in_vld).
//   in_vld  : per-lane valid
//   in_addr : lane i at [i*ADDRW +: ADDRW]
//   in_data : lane i at [i*DATAW +: DATAW]
//   c_addr  : compacted slot j at [j*ADDRW +: ADDRW] (unused slots zero)
//   c_data  : compacted slot j at [j*DATAW +: DATAW] (unused slots zero)
//   nv      : number of valid lanes
module wb_compact #(
  parameter int unsigned ADDRW  = 4,
  parameter int unsigned DATAW  = 64,
  parameter int unsigned NLANES = 4,
  parameter int unsigned NVW    = 3
) (
  input  logic [NLANES-1:0]       in_vld,
  input  logic [ADDRW*NLANES-1:0] in_addr,
  input  logic [DATAW*NLANES-1:0] in_data,
  output logic [ADDRW*NLANES-1:0] c_addr,
  output logic [DATAW*NLANES-1:0] c_data,
  output logic [NVW-1:0]          nv
);

  int unsigned k;

  // k is the running prefix count: the slot the next valid lane lands in.
  always_comb begin
    c_addr = '0;
    c_data = '0;
    k      = 0;
    for (int unsigned i = 0; i < NLANES; i++) begin
      if (in_vld[i]) begin
        c_addr[k*ADDRW +: ADDRW] = in_addr[i*ADDRW +: ADDRW];
        c_data[k*DATAW +: DATAW] = in_data[i*DATAW +: DATAW];
        k = k + 1;
      end
    end
    nv = NVW'(k);
  end

endmodule

// File: rtl/rf_wb_serializer.sv
// rf_wb_serializer: queues up to NLANES register writes per cycle and drains
// one per cycle onto the single register-file write port, with per-read-port
// pending-write hazard flags for the issue stage.
//   clk, rst            : clock, synchronous active-high reset
//   in_vld/in_addr/in_data : write bundle (lane-packed), taken when in_rdy=1
//   in_rdy              : whole bundle accepted this cycle
//   WEnb/WAddr/WData    : registered register-file write port
//   RAddr               : issue-stage read addresses, port r at [r*ADDRW +: ADDRW]
//   pend_hit            : read port r targets a still-pending write
//   busy                : queue non-empty or a write is on the port
module rf_wb_serializer
  import rf_wb_serializer_pkg::*;
#(
  parameter  int unsigned MEMD    = 16,
  parameter  int unsigned DATAW   = 64,
  parameter  int unsigned NLANES  = 4,
  parameter  int unsigned nRPORTS = 3,
  parameter  int unsigned QDEPTH  = 8,
  parameter  int unsigned BYPASS  = 1,
  localparam int unsigned ADDRW   = log2(MEMD)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NLANES-1:0]        in_vld,
  input  logic [ADDRW*NLANES-1:0]  in_addr,
  input  logic [DATAW*NLANES-1:0]  in_data,
  output logic                     in_rdy,
  output logic                     WEnb,
  output logic [ADDRW-1:0]         WAddr,
  output logic [DATAW-1:0]         WData,
  input  logic [ADDRW*nRPORTS-1:0] RAddr,
  output logic [nRPORTS-1:0]       pend_hit,
  output logic                     busy
);

  localparam int unsigned NVW = log2(NLANES + 1);
  localparam int unsigned PW  = log2(QDEPTH);
  localparam int unsigned CW  = log2(QDEPTH + 1);

  logic [ADDRW*NLANES-1:0] c_addr, e_addr;
  logic [DATAW*NLANES-1:0] c_data, e_data;
  logic [NVW-1:0]          nv, enq_n;

  logic [ADDRW-1:0] q_addr [QDEPTH];
  logic [DATAW-1:0] q_data [QDEPTH];
  logic [PW-1:0]    rd, wr, rd_nxt, wr_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic             acc, pop, bypass;

  wb_compact #(
    .ADDRW (ADDRW),
    .DATAW (DATAW),
    .NLANES(NLANES),
    .NVW   (NVW)
  ) u_compact (
    .in_vld (in_vld),
    .in_addr(in_addr),
    .in_data(in_data),
    .c_addr (c_addr),
    .c_data (c_data),
    .nv     (nv)
  );

  assign in_rdy = !rst && (count <= CW'(QDEPTH - NLANES));
  assign busy   = (count != '0) || WEnb;

  // With an empty queue, slot 0 of an accepted bundle goes straight to the
  // output register; only the remaining slots (shifted down) are enqueued.
  always_comb begin
    acc    = in_rdy && (nv != '0);
    pop    = (count != '0);
    bypass = acc && !pop;
    e_addr = c_addr;
    e_data = c_data;
    enq_n  = acc ? nv : '0;
    if (bypass) begin
      e_addr = c_addr >> ADDRW;
      e_data = c_data >> DATAW;
      enq_n  = nv - NVW'(1);
    end
    count_nxt = count + CW'(enq_n) - CW'(pop);
    wr_nxt    = PW'((32'(wr) + 32'(enq_n)) % QDEPTH);
    rd_nxt    = pop ? PW'((32'(rd) + 1) % QDEPTH) : rd;
  end

  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < NLANES; j++) begin
      if (j < 32'(enq_n)) begin
        q_addr[PW'((32'(wr) + j) % QDEPTH)] <= e_addr[j*ADDRW +: ADDRW];
        q_data[PW'((32'(wr) + j) % QDEPTH)] <= e_data[j*DATAW +: DATAW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      rd    <= '0;
      wr    <= '0;
      WEnb  <= 1'b0;
      WAddr <= '0;
      WData <= '0;
    end else begin
      if (pop) begin
        WEnb  <= 1'b1;
        WAddr <= q_addr[rd];
        WData <= q_data[rd];
      end else if (bypass) begin
        WEnb  <= 1'b1;
        WAddr <= c_addr[ADDRW-1:0];
        WData <= c_data[DATAW-1:0];
      end else begin
        WEnb  <= 1'b0;
      end
      count <= count_nxt;
      rd    <= rd_nxt;
      wr    <= wr_nxt;
    end
  end

  // Entry k is occupied when its distance from the read pointer is < count.
  always_comb begin
    pend_hit = '0;
    for (int unsigned r = 0; r < nRPORTS; r++) begin
      for (int unsigned k = 0; k < QDEPTH; k++) begin
        if ((((k + QDEPTH - 32'(rd)) % QDEPTH) < 32'(count)) &&
            (q_addr[PW'(k)] == RAddr[r*ADDRW +: ADDRW]))
          pend_hit[r] = 1'b1;
      end
      if ((BYPASS == 0) && WEnb && (WAddr == RAddr[r*ADDRW +: ADDRW]))
        pend_hit[r] = 1'b1;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CW'(QDEPTH));

endmodule
